uart_tx_sched: RTL and testbench

//  Shares the CPU's single UART transmit line (uart_tx) between NUM_REQ byte-stream requesters
//  (CPU store port, debug monitor, ...). Round-robin arbitration with packet lock.

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/uart_tx_shifter.sv | 80 ++++++++
 rtl/uart_tx_sched.sv | 128 ++++++++++++
 tb/tb_uart_tx_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART transmit scheduler and its shifter.
package uart_arb_pkg;

  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  function automatic int unsigned bit_cnt_w();
    return $clog2(UART_FRAME_BITS);
  endfunction

  function automatic int unsigned baud_cnt_w(input int unsigned cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 frame serialiser: start bit, d0..d7 LSB first, stop bit; done flags the last stop-bit cycle.
module uart_tx_shifter
  import uart_arb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned BW = baud_cnt_w(CLKS_PER_BIT);
  localparam int unsigned IW = bit_cnt_w();
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_STOP = IW'(UART_FRAME_BITS - 1);

  logic          active, active_nx;
  logic          tx_nx, done_nx;
  logic [7:0]    shreg, shreg_nx;
  logic [IW-1:0] bit_idx, bit_idx_nx;
  logic [BW-1:0] baud, baud_nx;

  always_comb begin
    active_nx  = active;
    tx_nx      = tx;
    shreg_nx   = shreg;
    bit_idx_nx = bit_idx;
    baud_nx    = baud;
    if (!active) begin
      tx_nx = 1'b1;
      if (start) begin
        active_nx  = 1'b1;
        tx_nx      = 1'b0;
        shreg_nx   = data;
        bit_idx_nx = '0;
        baud_nx    = '0;
      end
    end else if (baud != BAUD_MAX) begin
      baud_nx = BW'(baud + 1'b1);
    end else begin
      baud_nx = '0;
      if (bit_idx == IDX_STOP) begin
        active_nx = 1'b0;
        tx_nx     = 1'b1;
      end else begin
        bit_idx_nx = IW'(bit_idx + 1'b1);
        if (bit_idx_nx == IDX_STOP) begin
          tx_nx = 1'b1;
        end else begin
          tx_nx    = shreg[0];
          shreg_nx = {1'b0, shreg[7:1]};
        end
      end
    end
    // done is registered, so it is derived from the state the next cycle will be in
    done_nx = active_nx && (bit_idx_nx == IDX_STOP) && (baud_nx == BAUD_MAX);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      active  <= 1'b0;
      tx      <= 1'b1;
      done    <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
      baud    <= '0;
    end else begin
      active  <= active_nx;
      tx      <= tx_nx;
      done    <= done_nx;
      shreg   <= shreg_nx;
      bit_idx <= bit_idx_nx;
      baud    <= baud_nx;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin, packet-locked sharing of one UART tx line among NUM_REQ byte streams.
// Optional packet-lock timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_sched
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned CLKS_PER_BIT   = 434,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CLKS_PER_BIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_sched: parameter out of range");
  end

  state_t               state, state_nx;
  logic [GW-1:0]        rr_ptr, rr_nx, grant_nx, pick;
  logic                 last_q, last_nx;
  logic [NUM_REQ-1:0]   ready_nx;
  logic                 busy_nx, timeout_nx;
  logic                 found, accept_c, shift_done, to_hit;
  int unsigned          cand;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] g);
    return (g == GW'(NUM_REQ - 1)) ? '0 : GW'(g + 1'b1);
  endfunction

  assign accept_c = (state == WAIT) && req_valid[grant_id] && req_ready[grant_id];

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[GW'(cand)]) begin
        pick  = GW'(cand);
        found = 1'b1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] to_cnt, to_cnt_nx;

  assign to_hit    = (state == WAIT) && !accept_c && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign to_cnt_nx = ((state == WAIT) && !accept_c && !to_hit) ? CW'(to_cnt + 1'b1) : '0;

  always_ff @(posedge clk_in) begin
    if (!reset_in) to_cnt <= '0;
    else           to_cnt <= to_cnt_nx;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      ARB:     if (|req_valid) state_nx = WAIT;
      WAIT:    if (accept_c) state_nx = SEND;
               else if (to_hit) state_nx = ARB;
      SEND:    if (shift_done) state_nx = last_q ? ARB : WAIT;
      default: state_nx = ARB;
    endcase
  end

  // Next values of the registered outputs and arbitration bookkeeping
  always_comb begin
    grant_nx   = grant_id;
    rr_nx      = rr_ptr;
    last_nx    = last_q;
    timeout_nx = to_hit;
    if (state == ARB && found) grant_nx = pick;
    if (accept_c) last_nx = req_last[grant_id];
    if ((state == SEND && shift_done && last_q) || to_hit) rr_nx = next_idx(grant_id);
    ready_nx = (state_nx == WAIT) ? (NUM_REQ'(1) << grant_nx) : '0;
    busy_nx  = (state_nx != ARB);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state     <= ARB;
      rr_ptr    <= '0;
      grant_id  <= '0;
      last_q    <= 1'b0;
      req_ready <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      grant_id  <= grant_nx;
      last_q    <= last_nx;
      req_ready <= ready_nx;
      busy      <= busy_nx;
      timeout   <= timeout_nx;
    end
  end

  uart_tx_shifter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_shifter (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .start   (accept_c),
    .data    (req_data[{grant_id, 3'b000} +: 8]),
    .tx      (uart_tx),
    .done    (shift_done)
  );

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (NUM_REQ=2, CLKS_PER_BIT=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_sched;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic        uart_tx, busy, timeout;
  logic [0:0]  grant_id;

  int passed = 0;
  int total  = 0;

  uart_tx_sched #(
    .NUM_REQ(2),
    .CLKS_PER_BIT(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .grant_id (grant_id),
    .timeout  (timeout)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    tick();
    tick();
    reset_in = 1'b1;
  endtask

  // Wait for a start bit with the line held high meanwhile; gap 0 means don't check the wait length
  task automatic wait_start(input logic [0:0] g, input int gap, input string tag);
    int n = 0;
    while (uart_tx === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(32'(uart_tx), 0, {tag, "_start"});
    chk(32'(grant_id), 32'(g), {tag, "_grant"});
    if (gap > 0) chk(n, gap, {tag, "_gap"});
  endtask

  task automatic check_bits(input logic [7:0] b, input string tag);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        chk(32'(uart_tx), 32'(frame[i]), tag);
        tick();
      end
    end
  endtask

  initial begin
    // Reset and idle
    do_reset();
    tick();
    chk(32'(uart_tx), 1, "idle_tx");
    chk(32'(req_ready), 0, "idle_ready");
    chk(32'(busy), 0, "idle_busy");
    chk(32'(grant_id), 0, "idle_grant");
    chk(32'(timeout), 0, "idle_timeout");

    // 1: single byte 0xA5 from req0
    req_valid = 2'b01; req_data[7:0] = 8'hA5; req_last = 2'b01;
    chk(32'(req_ready), 0, "t1_no_comb_ready");
    tick();
    chk(32'(req_ready), 2'b01, "t1_ready");
    chk(32'(busy), 1, "t1_busy");
    wait_start(1'b0, 1, "t1");
    req_valid = 2'b00;
    chk(32'(req_ready), 0, "t1_ready_send");
    check_bits(8'hA5, "t1_bits");
    chk(32'(busy), 0, "t1_busy_after");
    chk(32'(uart_tx), 1, "t1_tx_after");

    // 2: simultaneous valid with rr_ptr=0
    do_reset();
    req_valid = 2'b11; req_data = {8'hC3, 8'h3C}; req_last = 2'b11;
    tick();
    chk(32'(grant_id), 0, "t2_grant0");
    chk(32'(req_ready), 2'b01, "t2_ready0");
    wait_start(1'b0, 1, "t2a");
    req_valid[0] = 1'b0;
    check_bits(8'h3C, "t2a_bits");
    wait_start(1'b1, 2, "t2b");
    req_valid[1] = 1'b0;
    check_bits(8'hC3, "t2b_bits");

    // 3: req1 three-byte packet while req0 stays valid; first pick proves rr_ptr is back at 0
    req_valid = 2'b11; req_data = {8'h11, 8'h5A}; req_last = 2'b01;
    wait_start(1'b0, 0, "t3_rr0");
    check_bits(8'h5A, "t3_r0_bits");
    wait_start(1'b1, 2, "t3_b1");
    req_data[15:8] = 8'h22;
    check_bits(8'h11, "t3_b1_bits");
    wait_start(1'b1, 1, "t3_b2");
    req_data[15:8] = 8'h33; req_last[1] = 1'b1;
    check_bits(8'h22, "t3_b2_bits");
    wait_start(1'b1, 1, "t3_b3");
    req_valid[1] = 1'b0;
    check_bits(8'h33, "t3_b3_bits");
    wait_start(1'b0, 2, "t3_r0_again");
    req_valid[0] = 1'b0;
    check_bits(8'h5A, "t3_r0_again_bits");

    // 4: reset during data bit 3 of 0x96 (bit 3 is 0)
    req_valid = 2'b01; req_data[7:0] = 8'h96; req_last = 2'b01;
    wait_start(1'b0, 2, "t4");
    req_valid = 2'b00;
    for (int k = 0; k < 17; k++) tick();
    chk(32'(uart_tx), 0, "t4_mid_bit3");
    reset_in = 1'b0;
    tick();
    chk(32'(uart_tx), 1, "t4_tx_reset");
    chk(32'(busy), 0, "t4_busy_reset");
    chk(32'(req_ready), 0, "t4_ready_reset");
    reset_in = 1'b1;
    tick();
    chk(32'(uart_tx), 1, "t4_tx_after");
    chk(32'(busy), 0, "t4_arb_after");
    req_valid = 2'b10; req_data[15:8] = 8'h0F; req_last = 2'b10;
    wait_start(1'b1, 2, "t4_next");
    req_valid = 2'b00;
    check_bits(8'h0F, "t4_next_bits");

    // 5: req0 stalls inside a packet while req1 waits
    do_reset();
    req_valid = 2'b11; req_data = {8'h7E, 8'h81}; req_last = 2'b10;
    wait_start(1'b0, 2, "t5_b1");
    req_valid[0] = 1'b0;
    check_bits(8'h81, "t5_b1_bits");
`ifdef UART_ARB_TIMEOUT_EN
    for (int w = 1; w <= 16; w++) begin
      chk(32'(timeout), 0, "t5_no_timeout");
      chk(32'(busy), 1, "t5_busy_wait");
      tick();
    end
    chk(32'(timeout), 1, "t5_timeout_pulse");
    chk(32'(busy), 0, "t5_arb");
    tick();
    chk(32'(timeout), 0, "t5_pulse_end");
    chk(32'(grant_id), 1, "t5_grant1");
    chk(32'(req_ready), 2'b10, "t5_ready1");
    wait_start(1'b1, 1, "t5_r1");
`else
    for (int w = 0; w < 40; w++) begin
      chk(32'(grant_id), 0, "t5_lock_grant");
      chk(32'(req_ready), 2'b01, "t5_lock_ready");
      chk(32'(timeout), 0, "t5_timeout_tied");
      tick();
    end
    req_valid[0] = 1'b1; req_data[7:0] = 8'h42; req_last[0] = 1'b1;
    wait_start(1'b0, 1, "t5_release");
    req_valid[0] = 1'b0;
    check_bits(8'h42, "t5_release_bits");
    wait_start(1'b1, 2, "t5_r1");
`endif
    req_valid[1] = 1'b0;
    check_bits(8'h7E, "t5_r1_bits");

    // 6: back-to-back single-byte packets, strict alternation
    do_reset();
    req_valid = 2'b11; req_data = {8'h3C, 8'hF0}; req_last = 2'b11;
    for (int r = 0; r < 4; r++) begin
      wait_start(1'(r % 2), 2, "t6_round");
      if (r == 3) req_valid = 2'b00;
      check_bits((r % 2 == 1) ? 8'h3C : 8'hF0, "t6_bits");
    end
    chk(32'(busy), 0, "t6_idle_busy");
    chk(32'(uart_tx), 1, "t6_idle_tx");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
